// File: rtl/core_mem_arbiter_pkg.sv
// Shared definitions for the imem/dmem memory arbiter: bus widths derived from
// the core memory ranges, owner state encoding and default starvation limit.
package core_mem_arbiter_pkg;

  localparam int unsigned MEM_ADDR_R = 63;
  localparam int unsigned MEM_DATA_R = 63;
  localparam int unsigned MEM_STRB_R = 7;

  localparam int unsigned ADDR_W = MEM_ADDR_R + 1;
  localparam int unsigned DATA_W = MEM_DATA_R + 1;
  localparam int unsigned STRB_W = MEM_STRB_R + 1;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Bus owner: IDLE arbitrates, OWN_x holds the bus until the request completes
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of the three req/gnt ports around the arbiter (fetch, LSU, shared bus).
// Modports:
//   slave  - arbiter view: requester requests in, responses out; bus request out, bus response in
//   master - environment view (requesters + memory), the mirror of slave
interface core_mem_arbiter_if import core_mem_arbiter_pkg::*; ();

  // Fetch requester (read-only)
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_err;
  logic [DATA_W-1:0] imem_rdata;

  // LSU requester
  logic              dmem_req;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_wen;
  logic [STRB_W-1:0] dmem_strb;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_err;
  logic [DATA_W-1:0] dmem_rdata;

  // Shared memory bus
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [STRB_W-1:0] mem_strb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_err;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_err, imem_rdata,
    input  dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    output dmem_gnt, dmem_err, dmem_rdata,
    output mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
    input  mem_gnt, mem_err, mem_rdata
  );

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_err, imem_rdata,
    output dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    input  dmem_gnt, dmem_err, dmem_rdata,
    input  mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
    output mem_gnt, mem_err, mem_rdata
  );

endinterface

// File: rtl/core_mem_arbiter.sv
// Two-to-one arbiter sharing one memory port between fetch (imem) and LSU (dmem).
// dmem wins by default; a saturating starvation counter hands the bus to imem
// after STARVE_LIMIT consecutive waiting cycles. Once a request is on the bus the
// owner is locked until it completes. Bus drive and responses are combinational.
// Ports:
//   g_clk    - clock
//   g_resetn - synchronous active-low reset
//   bus      - core_mem_arbiter_if.slave (imem_*, dmem_*, mem_* handshakes)
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                      g_clk,
  input  logic                      g_resetn,
  core_mem_arbiter_if.slave         bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_owner_e       r_owner;
  arb_owner_e       w_owner_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_nxt;

  logic w_sel_i;
  logic w_sel_d;
  logic w_starved;
  logic w_mem_req;
  logic w_mem_gnt;
  logic w_imem_gnt;

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // State registers
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_owner      <= ARB_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Selection, bus drive, response routing and next state
  always_comb begin
    w_sel_i      = 1'b0;
    w_sel_d      = 1'b0;
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve_cnt;

    unique case (r_owner)
      ARB_OWN_I: w_sel_i = 1'b1;
      ARB_OWN_D: w_sel_d = 1'b1;
      default: begin
        // dmem priority unless imem has waited STARVE_LIMIT cycles
        w_sel_d = bus.dmem_req & ~(bus.imem_req & w_starved);
        w_sel_i = bus.imem_req & ~w_sel_d;
      end
    endcase

    w_mem_req  = g_resetn & ((w_sel_i & bus.imem_req) | (w_sel_d & bus.dmem_req));
    w_mem_gnt  = bus.mem_gnt & w_mem_req;
    w_imem_gnt = w_sel_i & w_mem_gnt;

    bus.mem_req   = w_mem_req;
    bus.mem_addr  = w_sel_d ? bus.dmem_addr : bus.imem_addr;
    bus.mem_wen   = w_sel_d & bus.dmem_wen;
    bus.mem_strb  = w_sel_d ? bus.dmem_strb : '0;
    bus.mem_wdata = w_sel_d ? bus.dmem_wdata : '0;

    bus.imem_gnt   = w_imem_gnt;
    bus.imem_err   = w_sel_i & bus.mem_err;
    bus.imem_rdata = w_sel_i ? bus.mem_rdata : '0;
    bus.dmem_gnt   = w_sel_d & w_mem_gnt;
    bus.dmem_err   = w_sel_d & bus.mem_err;
    bus.dmem_rdata = w_sel_d ? bus.mem_rdata : '0;

    unique case (r_owner)
      ARB_OWN_I, ARB_OWN_D: begin
        // Completion, or the owner abandoned its request
        if (!w_mem_req || bus.mem_gnt) w_owner_nxt = ARB_IDLE;
      end
      default: begin
        // Single-cycle transactions never leave IDLE
        if (w_mem_req && !bus.mem_gnt) w_owner_nxt = w_sel_d ? ARB_OWN_D : ARB_OWN_I;
        else                           w_owner_nxt = ARB_IDLE;
      end
    endcase

    if (!bus.imem_req || w_imem_gnt) w_starve_nxt = '0;
    else if (!w_starved)             w_starve_nxt = r_starve_cnt + CNT_W'(1);
  end

  // Owner must hold its request until granted
  arb_req_dropped: assert property (@(posedge g_clk) disable iff (!g_resetn)
    !(((r_owner == ARB_OWN_I) && !bus.imem_req) ||
      ((r_owner == ARB_OWN_D) && !bus.dmem_req)));

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: table vectors, directed multi-cycle
// sequences and a response scoreboard (expected responses queued at drive time).
module tb_core_mem_arbiter;
  import core_mem_arbiter_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic g_clk = 1'b0;
  logic g_resetn;
  always #5 g_clk = ~g_clk;

  core_mem_arbiter_if bus();

  core_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          who;   // 1 = imem, 2 = dmem
    logic        err;
    logic [63:0] rdata;
  } rsp_t;
  rsp_t sb_q[$];

  typedef struct {
    logic        ireq;
    logic [63:0] iaddr;
    logic        dreq;
    logic [63:0] daddr;
    logic        dwen;
    logic [7:0]  dstrb;
    logic [63:0] dwdata;
    logic        gnt;
    logic        err;
    logic [63:0] rdata;
    int          exp_sel;   // 0 none, 1 imem, 2 dmem
    arb_owner_e  exp_own;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic ireq, input logic [63:0] iaddr,
                       input logic dreq, input logic [63:0] daddr, input logic dwen,
                       input logic [7:0] dstrb, input logic [63:0] dwdata,
                       input logic gnt, input logic err, input logic [63:0] rdata);
    bus.imem_req   = ireq;
    bus.imem_addr  = iaddr;
    bus.dmem_req   = dreq;
    bus.dmem_addr  = daddr;
    bus.dmem_wen   = dwen;
    bus.dmem_strb  = dstrb;
    bus.dmem_wdata = dwdata;
    bus.mem_gnt    = gnt;
    bus.mem_err    = err;
    bus.mem_rdata  = rdata;
  endtask

  task automatic drive_idle();
    drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 8'h0, 64'h0, 1'b0, 1'b0, 64'h0);
  endtask

  // Compare outputs against the expected selection, then run the scoreboard
  task automatic sample(input string tag, input int exp_sel);
    rsp_t r;
    if (exp_sel == 0) begin
      chk({tag, ".mem_req"},  64'(bus.mem_req), 64'(0));
      chk({tag, ".imem_gnt"}, 64'(bus.imem_gnt), 64'(0));
      chk({tag, ".dmem_gnt"}, 64'(bus.dmem_gnt), 64'(0));
    end else if (exp_sel == 1) begin
      chk({tag, ".mem_req"},    64'(bus.mem_req), 64'(bus.imem_req));
      chk({tag, ".mem_addr"},   bus.mem_addr, bus.imem_addr);
      chk({tag, ".mem_wen"},    64'(bus.mem_wen), 64'(0));
      chk({tag, ".mem_strb"},   64'(bus.mem_strb), 64'(0));
      chk({tag, ".mem_wdata"},  bus.mem_wdata, 64'(0));
      chk({tag, ".imem_gnt"},   64'(bus.imem_gnt), 64'(bus.mem_gnt & bus.imem_req));
      chk({tag, ".imem_err"},   64'(bus.imem_err), 64'(bus.mem_err));
      chk({tag, ".imem_rdata"}, bus.imem_rdata, bus.mem_rdata);
      chk({tag, ".dmem_gnt"},   64'(bus.dmem_gnt), 64'(0));
      chk({tag, ".dmem_err"},   64'(bus.dmem_err), 64'(0));
      chk({tag, ".dmem_rdata"}, bus.dmem_rdata, 64'(0));
      if (bus.imem_req && bus.mem_gnt) begin
        r.who = 1; r.err = bus.mem_err; r.rdata = bus.mem_rdata;
        sb_q.push_back(r);
      end
    end else begin
      chk({tag, ".mem_req"},    64'(bus.mem_req), 64'(bus.dmem_req));
      chk({tag, ".mem_addr"},   bus.mem_addr, bus.dmem_addr);
      chk({tag, ".mem_wen"},    64'(bus.mem_wen), 64'(bus.dmem_wen));
      chk({tag, ".mem_strb"},   64'(bus.mem_strb), 64'(bus.dmem_strb));
      chk({tag, ".mem_wdata"},  bus.mem_wdata, bus.dmem_wdata);
      chk({tag, ".dmem_gnt"},   64'(bus.dmem_gnt), 64'(bus.mem_gnt & bus.dmem_req));
      chk({tag, ".dmem_err"},   64'(bus.dmem_err), 64'(bus.mem_err));
      chk({tag, ".dmem_rdata"}, bus.dmem_rdata, bus.mem_rdata);
      chk({tag, ".imem_gnt"},   64'(bus.imem_gnt), 64'(0));
      chk({tag, ".imem_err"},   64'(bus.imem_err), 64'(0));
      chk({tag, ".imem_rdata"}, bus.imem_rdata, 64'(0));
      if (bus.dmem_req && bus.mem_gnt) begin
        r.who = 2; r.err = bus.mem_err; r.rdata = bus.mem_rdata;
        sb_q.push_back(r);
      end
    end
    if (bus.imem_gnt || bus.dmem_gnt) begin
      chk({tag, ".sb_expected"}, 64'(sb_q.size() != 0), 64'(1));
      chk({tag, ".gnt_onehot"}, 64'(bus.imem_gnt & bus.dmem_gnt), 64'(0));
      if (sb_q.size() != 0) begin
        r = sb_q.pop_front();
        chk({tag, ".sb_who"},   64'(bus.dmem_gnt ? 2 : 1), 64'(r.who));
        chk({tag, ".sb_err"},   64'(bus.dmem_gnt ? bus.dmem_err : bus.imem_err), 64'(r.err));
        chk({tag, ".sb_rdata"}, bus.dmem_gnt ? bus.dmem_rdata : bus.imem_rdata, r.rdata);
      end
    end
  endtask

  // One cycle: inputs already driven at posedge+1, sample at +4, owner after edge
  task automatic tick(input string tag, input int exp_sel, input arb_owner_e exp_own);
    #3;
    sample(tag, exp_sel);
    @(posedge g_clk);
    #1;
    chk({tag, ".owner"}, 64'(dut.r_owner), 64'(exp_own));
  endtask

  task automatic chk_starve(input string tag, input int exp);
    chk({tag, ".starve_cnt"}, 64'(dut.r_starve_cnt), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 8'h00, 64'h0,    1'b0, 1'b0, 64'h0,    0, ARB_IDLE};
    vecs[1]  = '{1'b1, 64'h1000, 1'b0, 64'h0,    1'b0, 8'h00, 64'h0,    1'b1, 1'b0, 64'hA1A1, 1, ARB_IDLE};
    vecs[2]  = '{1'b0, 64'h0,    1'b1, 64'h2000, 1'b1, 8'hF0, 64'h5555, 1'b1, 1'b0, 64'hB2B2, 2, ARB_IDLE};
    vecs[3]  = '{1'b1, 64'h1008, 1'b1, 64'h2008, 1'b0, 8'hFF, 64'h0,    1'b1, 1'b0, 64'hC3C3, 2, ARB_IDLE};
    vecs[4]  = '{1'b1, 64'h1010, 1'b0, 64'h0,    1'b0, 8'h00, 64'h0,    1'b1, 1'b1, 64'hD4D4, 1, ARB_IDLE};
    vecs[5]  = '{1'b0, 64'h0,    1'b1, 64'h3,    1'b0, 8'h00, 64'h0,    1'b1, 1'b1, 64'hE5E5, 2, ARB_IDLE};
    vecs[6]  = '{1'b0, 64'h0,    1'b1, 64'h2010, 1'b0, 8'h00, 64'h0,    1'b0, 1'b0, 64'h0,    2, ARB_OWN_D};
    vecs[7]  = '{1'b1, 64'h1018, 1'b1, 64'h2010, 1'b0, 8'h00, 64'h0,    1'b1, 1'b0, 64'hF6F6, 2, ARB_IDLE};
    vecs[8]  = '{1'b1, 64'h1020, 1'b0, 64'h0,    1'b0, 8'h00, 64'h0,    1'b0, 1'b0, 64'h0,    1, ARB_OWN_I};
    vecs[9]  = '{1'b1, 64'h1020, 1'b1, 64'h2018, 1'b1, 8'h0F, 64'h7777, 1'b1, 1'b0, 64'h1717, 1, ARB_IDLE};
    vecs[10] = '{1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 8'h00, 64'h0,    1'b0, 1'b0, 64'h0,    0, ARB_IDLE};

    // Reset with both requesters active and a bus grant present
    g_resetn = 1'b0;
    drive(1'b1, 64'h40, 1'b1, 64'h80, 1'b1, 8'hFF, 64'h99, 1'b1, 1'b0, 64'h0);
    repeat (2) @(posedge g_clk);
    #4;
    chk("rst.mem_req",  64'(bus.mem_req), 64'(0));
    chk("rst.imem_gnt", 64'(bus.imem_gnt), 64'(0));
    chk("rst.dmem_gnt", 64'(bus.dmem_gnt), 64'(0));
    chk("rst.owner", 64'(dut.r_owner), 64'(ARB_IDLE));
    chk_starve("rst", 0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    drive_idle();
    tick("R", 0, ARB_IDLE);

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].daddr, vecs[i].dwen,
            vecs[i].dstrb, vecs[i].dwdata, vecs[i].gnt, vecs[i].err, vecs[i].rdata);
      tick($sformatf("V%0d", i), vecs[i].exp_sel, vecs[i].exp_own);
    end
    chk_starve("V", 0);

    // A: dmem store granted in the third cycle
    drive(1'b0, 64'h0, 1'b1, 64'h80000010, 1'b1, 8'h0F, 64'h1122334455667788, 1'b0, 1'b0, 64'h0);
    tick("A1", 2, ARB_OWN_D);
    tick("A2", 2, ARB_OWN_D);
    bus.mem_gnt = 1'b1;
    bus.mem_rdata = 64'hABCD;
    tick("A3", 2, ARB_IDLE);
    drive_idle();
    tick("A4", 0, ARB_IDLE);

    // B: both request together, dmem first, then imem
    drive(1'b1, 64'h500, 1'b1, 64'h600, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 64'h1234);
    tick("B1", 2, ARB_IDLE);
    chk_starve("B1", 1);
    bus.dmem_req = 1'b0;
    bus.mem_rdata = 64'h5678;
    tick("B2", 1, ARB_IDLE);
    chk_starve("B2", 0);
    drive_idle();
    tick("B3", 0, ARB_IDLE);

    // C: continuous contention, starvation forces imem on the fifth cycle
    drive(1'b1, 64'h700, 1'b1, 64'h800, 1'b1, 8'hFF, 64'hCAFE, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      bus.dmem_addr = 64'h800 + 64'(i * 8);
      bus.mem_rdata = 64'h100 + 64'(i);
      tick($sformatf("C%0d", i), 2, ARB_IDLE);
      chk_starve($sformatf("C%0d", i), i + 1);
    end
    bus.mem_rdata = 64'h200;
    tick("C4", 1, ARB_IDLE);
    chk_starve("C4", 0);
    drive_idle();
    tick("C5", 0, ARB_IDLE);

    // D: imem owns the bus for five cycles, dmem must wait
    drive(1'b1, 64'h900, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0);
    tick("D1", 1, ARB_OWN_I);
    bus.dmem_req   = 1'b1;
    bus.dmem_addr  = 64'hA00;
    bus.dmem_wen   = 1'b1;
    bus.dmem_strb  = 8'h3C;
    bus.dmem_wdata = 64'hBEEF;
    tick("D2", 1, ARB_OWN_I);
    tick("D3", 1, ARB_OWN_I);
    tick("D4", 1, ARB_OWN_I);
    chk_starve("D4", 4);
    bus.mem_gnt   = 1'b1;
    bus.mem_rdata = 64'h9999;
    tick("D5", 1, ARB_IDLE);
    chk_starve("D5", 0);
    bus.imem_req  = 1'b0;
    bus.mem_rdata = 64'h0;
    tick("D6", 2, ARB_IDLE);
    drive_idle();
    tick("D7", 0, ARB_IDLE);

    // E: reset while dmem owns the bus
    drive(1'b1, 64'hB00, 1'b1, 64'hC00, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0);
    tick("E1", 2, ARB_OWN_D);
    chk_starve("E1", 1);
    g_resetn = 1'b0;
    bus.mem_gnt = 1'b1;
    #3;
    chk("E2.mem_req",  64'(bus.mem_req), 64'(0));
    chk("E2.imem_gnt", 64'(bus.imem_gnt), 64'(0));
    chk("E2.dmem_gnt", 64'(bus.dmem_gnt), 64'(0));
    @(posedge g_clk);
    #1;
    chk("E2.owner", 64'(dut.r_owner), 64'(ARB_IDLE));
    chk_starve("E2", 0);
    g_resetn = 1'b1;
    bus.mem_rdata = 64'h4242;
    tick("E3", 2, ARB_IDLE);
    drive_idle();
    tick("E4", 0, ARB_IDLE);

    chk("sb.drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
